// File: rtl/plru_tree_n_if.sv
// plru_tree_n_if: cache-controller side bundle for the tree pseudo-LRU unit.
interface plru_tree_n_if #(
    parameter int WAYS = 4,
    parameter int SETS = 8
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

    logic             touch_valid;
    logic [IDX_W-1:0] touch_index;
    logic [WAY_W-1:0] touch_way;
    logic             victim_req;
    logic [IDX_W-1:0] victim_index;
    logic [WAYS-1:0]  valid_mask;
    logic             victim_valid;
    logic [WAY_W-1:0] victim_way;
    logic             flush_req;
    logic             flush_busy;

    modport master (
        output touch_valid, touch_index, touch_way, victim_req, victim_index, valid_mask, flush_req,
        input  victim_valid, victim_way, flush_busy
    );

    modport slave (
        input  touch_valid, touch_index, touch_way, victim_req, victim_index, valid_mask, flush_req,
        output victim_valid, victim_way, flush_busy
    );
endinterface

// File: rtl/plru_tree_n.sv
// plru_tree_n: per-set heap-ordered PLRU tree with touch update, registered victim
// select (empty ways first) and a one-set-per-cycle flush sweep.
module plru_tree_n #(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input logic          clk,
    input logic          reset_n,
    plru_tree_n_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [NODES-1:0] tree [SETS];
    logic [NODES-1:0] upd;
    logic [NODES-1:0] cur;
    logic [WAY_W-1:0] walk;
    logic [WAY_W-1:0] first_free;
    logic             touch_en;

    assign touch_en = bus.touch_valid && state == IDLE;

    // Every node on the root-to-leaf path is aimed at the sibling subtree.
    always_comb begin
        int tw;
        tw = int'(bus.touch_way);
        upd = tree[bus.touch_index];
        for (int l = 0; l < WAY_W; l++)
            upd[(1 << l) - 1 + (tw >> (WAY_W - l))] = ((tw >> (WAY_W - 1 - l)) & 1) == 0;
    end

    always_comb begin
        int w;
        cur = tree[bus.victim_index];
        w = 0;
        for (int l = 0; l < WAY_W; l++)
            w = 2 * w + (cur[(1 << l) - 1 + w] ? 1 : 0);
        walk = WAY_W'(w);
        first_free = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (!bus.valid_mask[i]) first_free = WAY_W'(i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.flush_busy   <= 1'b0;
            bus.victim_valid <= 1'b0;
            bus.victim_way   <= '0;
            for (int s = 0; s < SETS; s++) tree[s] <= '0;
        end else begin
            bus.victim_valid <= bus.victim_req;
            if (bus.victim_req) bus.victim_way <= &bus.valid_mask ? walk : first_free;
            if (touch_en) tree[bus.touch_index] <= upd;
            if (state == FLUSH) begin
                tree[cnt] <= '0;
                cnt       <= cnt + 1'b1;
                if (cnt == IDX_W'(SETS - 1)) begin
                    state          <= IDLE;
                    bus.flush_busy <= 1'b0;
                end
            end else if (bus.flush_req) begin
                state          <= FLUSH;
                cnt            <= '0;
                bus.flush_busy <= 1'b1;
            end
        end
    end
endmodule

// File: doc/plru_tree_n.md
# plru_tree_n

Parametrised tree pseudo-LRU replacement unit for an N-way set-associative cache. It keeps one (WAYS−1)-bit tree per set and updates the tree on every access ("touch"). On request it returns a registered victim way, and invalid ways take priority over the tree choice. It also provides a sequential flush sweep that returns every set to the reset tree. It sits beside the tag/data arrays in the cache datapath; the cache controller drives touches on hits and fills, and requests victims on misses.

## Interface
- WAYS, 4, associativity; power of two, 2..16
- SETS, 8, number of sets; power of two, ≥2
- IDX_W, $clog2(SETS), derived index width
- WAY_W, $clog2(WAYS), derived way width
- clk  in  1  rising-edge clock (single clock domain)
- reset_n  in  1  asynchronous, active-low reset
- touch_valid  in  1  update the tree for touch_index/touch_way this cycle
- touch_index  in  IDX_W  set being accessed
- touch_way  in  WAY_W  way being accessed
- victim_req  in  1  request a victim for victim_index
- victim_index  in  IDX_W  set needing replacement
- valid_mask  in  WAYS  per-way valid bits of victim_index; bit w=0 means way w is empty
- victim_valid  out  1  one-cycle pulse; victim_way holds the answer
- victim_way  out  WAY_W  selected victim
- flush_req  in  1  start the flush sweep (level-sampled in IDLE)
- flush_busy  out  1  high while the sweep runs

## Operation
- Tree layout per set: heap order. Node 0 is the root, and node k has children 2k+1 and 2k+2. Leaves map left-to-right to ways 0..WAYS−1.
- Node bit 0 points the victim left (lower ways); bit 1 points it right.
- Touch, when touch_valid=1 and not flushing: every node on the path to touch_way is written to point away from touch_way. Nodes off the path are unchanged.
- Victim selection:
  - If valid_mask ≠ all-ones, the victim is the lowest-index way whose valid_mask bit is 0.
  - Otherwise, walk the tree from the root following the node bits.
- The victim request does not modify the tree. The controller issues a touch when it fills the way.
- Flush FSM:
  - IDLE: flush_req=1 → FLUSH, with counter=0.
  - FLUSH: clear the tree of set[counter] to all-zero and increment the counter.
  - When counter=SETS−1 is cleared → IDLE.
  - flush_busy=1 exactly while in FLUSH.
  - flush_req during FLUSH is ignored. It is re-sampled in IDLE, so a held request restarts the sweep.
- During FLUSH:
  - touch_valid is dropped; no update occurs.
  - victim_req is still served with normal latency, reading the current (possibly partially cleared) state.
- Simultaneous touch and victim_req on the same set in one cycle: the victim is computed from the pre-touch state, and the touch takes effect at the same edge.
- Index wrap: not applicable, because all indices are in range by construction.

## Timing
- Reset (reset_n=0, asynchronous):
  - every tree = 0
  - FSM = IDLE, counter = 0
  - victim_valid = 0, victim_way = 0
  - flush_busy = 0
- A reset asserted mid-flush aborts the sweep immediately.
- Touch latency: the state updates at the edge that samples touch_valid. A victim_req in the next cycle sees the new state.
- Victim latency: 1 cycle. victim_req is sampled at edge t; victim_valid=1 and victim_way are registered at edge t. victim_valid is a single-cycle pulse per request.
  - Back-to-back requests give back-to-back pulses.
  - victim_way holds its value while victim_valid=0.
- No stall or ready signal exists: requests and touches are accepted every cycle.
- Flush duration: exactly SETS cycles with flush_busy=1. The cycle after the sampling edge is the first busy cycle.

## Test plan
- Reset, WAYS=4, SETS=8: release reset_n; victim_req set 5 with valid_mask=4'b1111 → next cycle victim_valid=1, victim_way=0; flush_busy=0.
- Touch sequence on set 3 with mask 1111:
  - touch way 0 → tree=3'b011 (nodes 2,1,0), victim=2
  - then touch way 2 → tree=3'b110, victim=1
  - then touch way 1 → victim=3
- Invalid priority: set 6 tree arbitrary; victim_req with valid_mask=4'b1011 → victim_way=2. With 4'b1110 → 0.
- Same-cycle collision: set 1 at reset state; touch way 0 and victim_req set 1 in the same cycle → victim_way=0 (pre-touch). A following request → 2.
- Flush:
  - touch ways in all 8 sets; pulse flush_req → flush_busy high for exactly 8 cycles.
  - a touch to set 7 during the sweep is dropped.
  - afterwards every set yields victim 0.
  - assert reset_n low at busy cycle 3 → flush_busy=0 immediately, and all sets read as reset.
- Parameter sweep: WAYS=8, SETS=4; touch ways 0..7 in order on set 2 → victim=0. Repeat for WAYS=2 → victims alternate.
